axi_stream_strip_header: RTL and testbench

AXI_STREAM_STRIP_HEADER -- requirements
Module: axi_stream_strip_header

---
 rtl/axi_stream_strip_header.sv | 194 +++++++++++++++++++
 tb/tb_axi_stream_strip_header.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_strip_header.sv
// Strips an L-byte header (L = byte_strip_cnt+1) from the first beat of each AXI-Stream
// packet, emits it on a side channel and realigns the remaining payload bytes to the MSB.
module axi_stream_strip_header #(
    parameter int  DATA_WIDTH      = 32,
    localparam int DATA_BYTE_WIDTH = DATA_WIDTH / 8,
    localparam int BYTE_CNT_WIDTH  = $clog2(DATA_BYTE_WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_in,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic [DATA_BYTE_WIDTH-1:0] keep_in,
    input  logic                       last_in,
    output logic                       ready_in,
    input  logic [BYTE_CNT_WIDTH-1:0]  byte_strip_cnt,
    output logic                       valid_out,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic [DATA_BYTE_WIDTH-1:0] keep_out,
    output logic                       last_out,
    input  logic                       ready_out,
    output logic                       valid_header,
    output logic [DATA_WIDTH-1:0]      data_header,
    output logic [DATA_BYTE_WIDTH-1:0] keep_header,
    input  logic                       ready_header
);

    localparam int LEN_WIDTH = BYTE_CNT_WIDTH + 1;
    localparam int SUM_WIDTH = LEN_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    function automatic logic [LEN_WIDTH-1:0] count_bytes(input logic [DATA_BYTE_WIDTH-1:0] keep);
        logic [LEN_WIDTH-1:0] cnt;
        cnt = {LEN_WIDTH{1'b0}};
        for (int i = 0; i < DATA_BYTE_WIDTH; i++) begin
            cnt = cnt + LEN_WIDTH'(keep[i]);
        end
        return cnt;
    endfunction

    // n ones starting at the MSB (byte 0); saturates to all ones for n >= byte width
    function automatic logic [DATA_BYTE_WIDTH-1:0] msb_keep(input logic [SUM_WIDTH-1:0] n);
        return ~({DATA_BYTE_WIDTH{1'b1}} >> n);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] keep_to_mask(input logic [DATA_BYTE_WIDTH-1:0] keep);
        logic [DATA_WIDTH-1:0] mask;
        for (int i = 0; i < DATA_BYTE_WIDTH; i++) begin
            mask[i*8 +: 8] = {8{keep[i]}};
        end
        return mask;
    endfunction

    state_t                     r_state;
    logic [LEN_WIDTH-1:0]       r_len;
    logic [DATA_WIDTH-1:0]      r_res;
    logic [DATA_BYTE_WIDTH-1:0] r_flush_keep;
    logic                       r_valid_out;
    logic [DATA_WIDTH-1:0]      r_data_out;
    logic [DATA_BYTE_WIDTH-1:0] r_keep_out;
    logic                       r_last_out;
    logic                       r_valid_header;
    logic [DATA_WIDTH-1:0]      r_data_header;
    logic [DATA_BYTE_WIDTH-1:0] r_keep_header;

    logic [LEN_WIDTH-1:0]       w_l_in;
    logic [LEN_WIDTH-1:0]       w_len;
    logic [LEN_WIDTH-1:0]       w_res_len;
    logic [LEN_WIDTH-1:0]       w_v;
    logic [SUM_WIDTH-1:0]       w_sum;
    logic [SUM_WIDTH-1:0]       w_tail;
    logic                       w_fits;
    logic                       w_out_free;
    logic                       w_accept;
    logic [DATA_WIDTH-1:0]      w_data_m;
    logic [DATA_WIDTH-1:0]      w_shl;
    logic [DATA_WIDTH-1:0]      w_cat;
    logic [DATA_WIDTH-1:0]      w_hdr_data;
    logic [DATA_BYTE_WIDTH-1:0] w_hdr_keep;

    // The header length is only taken from the input on the first beat, then frozen
    assign w_l_in     = {1'b0, byte_strip_cnt} + LEN_WIDTH'(1'b1);
    assign w_len      = (r_state == IDLE) ? w_l_in : r_len;
    assign w_res_len  = LEN_WIDTH'(DATA_BYTE_WIDTH) - w_len;
    assign w_v        = count_bytes(keep_in);
    assign w_sum      = {1'b0, w_res_len} + {1'b0, w_v};
    assign w_tail     = {1'b0, w_v - w_len};
    assign w_fits     = (w_sum <= SUM_WIDTH'(DATA_BYTE_WIDTH));
    assign w_out_free = !r_valid_out || ready_out;
    assign w_accept   = valid_in && ready_in;

    // Invalid input bytes are zeroed up front so shifted results carry zero padding
    assign w_data_m   = data_in & keep_to_mask(keep_in);
    assign w_shl      = w_data_m << {w_len, 3'b000};
    assign w_cat      = r_res | (w_data_m >> {w_res_len, 3'b000});
    assign w_hdr_data = data_in & ~({DATA_WIDTH{1'b1}} >> {w_l_in, 3'b000});
    assign w_hdr_keep = msb_keep({1'b0, w_l_in}) & keep_in;

    // Input acceptance depends on which output slot the next beat would fill
    always_comb begin
        ready_in = 1'b0;
        case (r_state)
            IDLE:    ready_in = rst_n && (!r_valid_header || ready_header) && w_out_free;
            STREAM:  ready_in = rst_n && w_out_free;
            default: ready_in = 1'b0;
        endcase
    end

    // Packet FSM with registered payload and header output stages
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_len          <= {LEN_WIDTH{1'b0}};
            r_res          <= {DATA_WIDTH{1'b0}};
            r_flush_keep   <= {DATA_BYTE_WIDTH{1'b0}};
            r_valid_out    <= 1'b0;
            r_data_out     <= {DATA_WIDTH{1'b0}};
            r_keep_out     <= {DATA_BYTE_WIDTH{1'b0}};
            r_last_out     <= 1'b0;
            r_valid_header <= 1'b0;
            r_data_header  <= {DATA_WIDTH{1'b0}};
            r_keep_header  <= {DATA_BYTE_WIDTH{1'b0}};
        end else begin
            if (r_valid_header && ready_header) begin
                r_valid_header <= 1'b0;
            end
            if (r_valid_out && ready_out) begin
                r_valid_out <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_len          <= w_l_in;
                        r_res          <= w_shl;
                        r_valid_header <= 1'b1;
                        r_data_header  <= w_hdr_data;
                        r_keep_header  <= w_hdr_keep;
                        if (!last_in) begin
                            r_state <= STREAM;
                        end else if (w_v > w_l_in) begin
                            r_valid_out <= 1'b1;
                            r_data_out  <= w_shl;
                            r_keep_out  <= msb_keep(w_tail);
                            r_last_out  <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (w_accept) begin
                        r_valid_out <= 1'b1;
                        r_data_out  <= w_cat;
                        r_res       <= w_shl;
                        if (!last_in) begin
                            r_keep_out <= {DATA_BYTE_WIDTH{1'b1}};
                            r_last_out <= 1'b0;
                        end else if (w_fits) begin
                            r_keep_out <= msb_keep(w_sum);
                            r_last_out <= 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            r_keep_out   <= {DATA_BYTE_WIDTH{1'b1}};
                            r_last_out   <= 1'b0;
                            r_flush_keep <= msb_keep(w_tail);
                            r_state      <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (w_out_free) begin
                        r_valid_out <= 1'b1;
                        r_data_out  <= r_res;
                        r_keep_out  <= r_flush_keep;
                        r_last_out  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign valid_out    = r_valid_out;
    assign data_out     = r_data_out;
    assign keep_out     = r_keep_out;
    assign last_out     = r_last_out;
    assign valid_header = r_valid_header;
    assign data_header  = r_data_header;
    assign keep_header  = r_keep_header;

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Bench for axi_stream_strip_header: fixed vectors, stall/reset sequences and random packets
// checked against a byte-stream model of header stripping.
`timescale 1ns/1ps
module tb_axi_stream_strip_header;

    logic        clk = 1'b0;
    logic        rst_n, valid_in, last_in, ready_in, ready_out, ready_header;
    logic [31:0] data_in, data_out, data_header;
    logic [3:0]  keep_in, keep_out, keep_header;
    logic [1:0]  byte_strip_cnt;
    logic        valid_out, last_out, valid_header;

    always #5 clk = ~clk;

    axi_stream_strip_header #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
        .ready_in(ready_in), .byte_strip_cnt(byte_strip_cnt),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
        .ready_out(ready_out),
        .valid_header(valid_header), .data_header(data_header), .keep_header(keep_header),
        .ready_header(ready_header)
    );

    typedef struct { logic [31:0] d; logic [3:0] k; logic l; } beat_t;
    typedef struct {
        string name; int l; int n; logic [31:0] b0; logic [31:0] b1; logic [3:0] klast;
        logic [31:0] hd; logic [3:0] hk; int np;
        logic [31:0] p0; logic [3:0] pk0; logic [31:0] p1; logic [3:0] pk1;
    } vec_t;

    beat_t       exp_pay[$], got_pay[$], exp_hdr[$], got_hdr[$];
    int          checks = 0, errors = 0;
    logic        mon_en = 1'b0, rand_ready = 1'b0, rand_gaps = 1'b0;
    logic [31:0] pkt [8];
    vec_t        vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: records transfers and verifies a stalled payload beat holds steady
    initial begin
        beat_t prev;
        logic  prev_stall;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (prev_stall) begin
                    chk("hold_valid", valid_out, 1'b1);
                    chk("hold_beat", {data_out, keep_out, last_out}, {prev.d, prev.k, prev.l});
                end
                prev_stall = valid_out && !ready_out;
                prev = '{data_out, keep_out, last_out};
                if (valid_out && ready_out) got_pay.push_back('{data_out, keep_out, last_out});
                if (valid_header && ready_header) got_hdr.push_back('{data_header, keep_header, 1'b0});
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Random back-pressure on both output channels
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) begin
                ready_out    = ($urandom_range(0, 3) != 0);
                ready_header = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Sends pkt[0..n-1]; returns number of cycles any beat had to wait for ready_in
    task automatic send_pkt(input int l, input int n, input logic [3:0] klast, output int stalls);
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            bit acc;
            if (rand_gaps) begin
                valid_in = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            valid_in       = 1'b1;
            data_in        = pkt[i];
            keep_in        = (i == n - 1) ? klast : 4'hF;
            last_in        = (i == n - 1);
            byte_strip_cnt = (i == 0) ? 2'(l - 1) : 2'($urandom_range(0, 3));
            acc = 1'b0;
            for (int t = 0; t < 300 && !acc; t++) begin
                @(negedge clk);
                if (ready_in) acc = 1'b1;
                else stalls++;
            end
            @(posedge clk);
            #1;
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: beat %0d not accepted, required acceptance", i);
            end
        end
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    // Reference: header = first L bytes of beat 0; payload = remaining valid bytes regrouped
    task automatic model_pkt(input int l, input int n, input logic [3:0] klast);
        logic [7:0] pb[$];
        beat_t      h, p;
        int         v, idx;
        v = 0;
        for (int j = 0; j < 4; j++) v += klast[j];
        for (int i = 0; i < n; i++) begin
            int nv;
            nv = (i == n - 1) ? v : 4;
            for (int j = 0; j < nv; j++) pb.push_back(pkt[i][31-8*j -: 8]);
        end
        h = '{32'h0, 4'h0, 1'b0};
        for (int j = 0; j < l; j++) begin
            h.d[31-8*j -: 8] = pkt[0][31-8*j -: 8];
            h.k[3-j]         = (j < ((n == 1) ? v : 4));
        end
        exp_hdr.push_back(h);
        idx = l;
        while (idx < pb.size()) begin
            p = '{32'h0, 4'h0, 1'b0};
            for (int j = 0; j < 4; j++) begin
                if (idx < pb.size()) begin
                    p.d[31-8*j -: 8] = pb[idx];
                    p.k[3-j]         = 1'b1;
                    idx++;
                end
            end
            p.l = (idx >= pb.size());
            exp_pay.push_back(p);
        end
    endtask

    task automatic drain_compare(input string name);
        for (int t = 0; t < 300 && (got_pay.size() < exp_pay.size() || got_hdr.size() < exp_hdr.size()); t++)
            @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk({name, "_pay_count"}, got_pay.size(), exp_pay.size());
        chk({name, "_hdr_count"}, got_hdr.size(), exp_hdr.size());
        while (exp_pay.size() > 0 && got_pay.size() > 0) begin
            beat_t e, g;
            e = exp_pay.pop_front();
            g = got_pay.pop_front();
            chk({name, "_pay"}, {g.d, g.k, g.l}, {e.d, e.k, e.l});
        end
        while (exp_hdr.size() > 0 && got_hdr.size() > 0) begin
            beat_t e, g;
            e = exp_hdr.pop_front();
            g = got_hdr.pop_front();
            chk({name, "_hdr"}, {g.d, g.k}, {e.d, e.k});
        end
        exp_pay.delete(); got_pay.delete(); exp_hdr.delete(); got_hdr.delete();
    endtask

    task automatic run_vec(input vec_t vc, input string name);
        int st;
        pkt[0] = vc.b0;
        pkt[1] = vc.b1;
        exp_hdr.push_back('{vc.hd, vc.hk, 1'b0});
        if (vc.np >= 1) exp_pay.push_back('{vc.p0, vc.pk0, vc.np == 1});
        if (vc.np >= 2) exp_pay.push_back('{vc.p1, vc.pk1, 1'b1});
        send_pkt(vc.l, vc.n, vc.klast, st);
        drain_compare(name);
    endtask

    initial begin
        int st;
        vecs[0] = '{"v_l2",      2, 2, 32'h12345678, 32'h12345679, 4'b1100, 32'h12340000, 4'b1100, 1, 32'h56781234, 4'b1111, 32'h0, 4'h0};
        vecs[1] = '{"v_l1_fl",   1, 2, 32'h11223344, 32'h55667788, 4'b1111, 32'h11000000, 4'b1000, 2, 32'h22334455, 4'b1111, 32'h66778800, 4'b1110};
        vecs[2] = '{"v_l4",      4, 2, 32'hAABBCCDD, 32'h01020304, 4'b1110, 32'hAABBCCDD, 4'b1111, 1, 32'h01020300, 4'b1110, 32'h0, 4'h0};
        vecs[3] = '{"v_single",  3, 1, 32'hDEADBEEF, 32'h0,        4'b1111, 32'hDEADBE00, 4'b1110, 1, 32'hEF000000, 4'b1000, 32'h0, 4'h0};
        vecs[4] = '{"v_hdronly", 3, 1, 32'hDEADBEEF, 32'h0,        4'b1100, 32'hDEADBE00, 4'b1100, 0, 32'h0, 4'h0, 32'h0, 4'h0};
        vecs[5] = '{"v_l4_one",  4, 1, 32'h0BADF00D, 32'h0,        4'b1111, 32'h0BADF00D, 4'b1111, 0, 32'h0, 4'h0, 32'h0, 4'h0};
        vecs[6] = '{"v_l2_one",  2, 1, 32'hCAFEF00D, 32'h0,        4'b1110, 32'hCAFE0000, 4'b1100, 1, 32'hF0000000, 4'b1000, 32'h0, 4'h0};

        rst_n = 1'b0; valid_in = 1'b0; data_in = 32'h0; keep_in = 4'h0; last_in = 1'b0;
        byte_strip_cnt = 2'd0; ready_out = 1'b1; ready_header = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid_out", valid_out, 1'b0);
        chk("rst_valid_header", valid_header, 1'b0);
        chk("rst_out_regs", {data_out, keep_out, last_out}, 37'h0);
        chk("rst_hdr_regs", {data_header, keep_header}, 36'h0);
        chk("rst_ready_in", ready_in, 1'b1);
        @(posedge clk);
        #1 mon_en = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], vecs[i].name);

        // Back-to-back packets: second first beat must not wait
        pkt[0] = 32'h12345678; pkt[1] = 32'h12345679;
        model_pkt(2, 2, 4'b1100);
        send_pkt(2, 2, 4'b1100, st);
        chk("b2b_stall_a", st, 0);
        model_pkt(2, 2, 4'b1100);
        send_pkt(2, 2, 4'b1100, st);
        chk("b2b_stall_b", st, 0);
        drain_compare("b2b");

        // Header stalled at start, payload stalled mid-packet
        ready_header = 1'b0; ready_out = 1'b0;
        pkt[0] = 32'hA1A2A3A4; pkt[1] = 32'hB1B2B3B4; pkt[2] = 32'hC1C2C3C4;
        model_pkt(2, 3, 4'hF);
        fork
            send_pkt(2, 3, 4'hF, st);
            begin
                repeat (3) @(posedge clk);
                #1 ready_header = 1'b1;
                for (int t = 0; t < 20 && !valid_out; t++) @(negedge clk);
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_ready_in", ready_in, 1'b0);
                end
                @(posedge clk);
                #1 ready_out = 1'b1;
            end
        join
        drain_compare("stall");

        // Reset in the middle of a packet
        ready_out = 1'b0; ready_header = 1'b0;
        valid_in = 1'b1; data_in = 32'h01020304; keep_in = 4'hF; last_in = 1'b0; byte_strip_cnt = 2'd1;
        @(posedge clk);
        #1 data_in = 32'h05060708;
        @(posedge clk);
        #1 mon_en = 1'b0; data_in = 32'h090A0B0C; rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready_in", ready_in, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1; valid_in = 1'b0;
        @(negedge clk);
        chk("rst_mid_valids", {valid_out, valid_header, last_out}, 3'b000);
        chk("rst_mid_regs", {keep_out, keep_header, data_out, data_header}, 72'h0);
        @(posedge clk);
        #1 ready_out = 1'b1; ready_header = 1'b1; mon_en = 1'b1;
        got_pay.delete(); got_hdr.delete();
        run_vec(vecs[0], "after_reset");

        // Random packets with random gaps and back-pressure
        rand_ready = 1'b1; rand_gaps = 1'b1;
        for (int p = 0; p < 60; p++) begin
            int l, n, v;
            l = $urandom_range(1, 4);
            n = $urandom_range(1, 4);
            v = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) pkt[i] = $urandom;
            model_pkt(l, n, 4'hF << (4 - v));
            send_pkt(l, n, 4'hF << (4 - v), st);
        end
        rand_ready = 1'b0; rand_gaps = 1'b0;
        ready_out = 1'b1; ready_header = 1'b1;
        drain_compare("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
